pe_sequencer: RTL and testbench

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/pe_seq_if.sv | 22 ++
 rtl/pe_sequencer.sv | 120 ++++++++++++
 tb/tb_pe_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_seq_if.sv
// Operand-in / result-out handshake bundle between an upstream producer, the
// PE sequencer and a downstream result consumer.
interface pe_seq_if #(
   parameter int N = 16
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [N-1:0][31:0]   in_data;
   logic                 res_valid;
   logic                 res_ready;
   logic [31:0]          res_data;

   modport master (
      output in_valid, in_data, res_ready,
      input  in_ready, res_valid, res_data
   );

   modport slave (
      input  in_valid, in_data, res_ready,
      output in_ready, res_valid, res_data
   );
endinterface

// File: rtl/pe_sequencer.sv
// Sequences one PE dot-product job: load A, load B, N MAC cycles, a short drain,
// then hold the captured result until the downstream handshake completes.
module pe_sequencer #(
   parameter int N         = 16,
   parameter int DRAIN_CYC = 2,
   localparam int PCW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   pe_seq_if.slave             bus,
   output logic [N-1:0][31:0]  datain,
   output logic                write_mat,
   output logic                mat_mux,
   output logic                inc_pc,
   output logic                mac_ctrl,
   output logic                rst_mul,
   output logic [PCW-1:0]      pc_counter,
   input  logic [31:0]         dataout,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_B,
      S_MAC,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PCW-1:0]  pc_q, pc_d;
   logic [2:0]      drain_q, drain_d;
   logic            res_valid_q, res_valid_d;
   logic [31:0]     res_data_q, res_data_d;
   logic            in_ready_c;
   logic            xfer;

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge value of its neighbours; blocking here would create ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         drain_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drain_q     <= drain_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign in_ready_c = (state_q == S_IDLE) || (state_q == S_LOAD_B);
   assign xfer       = in_ready_c && bus.in_valid;

   // NOTE: every signal gets its hold value before the case statement, so no
   // path through the block leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drain_d     = drain_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      case (state_q)
         S_IDLE: begin
            if (xfer) state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
            if (xfer) begin
               state_d = S_MAC;
               pc_d    = '0;
            end
         end
         S_MAC: begin
            // Terminal count is N-1, not the counter's width maximum.
            if (pc_q == PCW'(N - 1)) begin
               pc_d    = '0;
               drain_d = '0;
               state_d = S_DRAIN;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == 3'(DRAIN_CYC - 1)) begin
               res_data_d  = dataout;
               res_valid_d = 1'b1;
               drain_d     = '0;
               state_d     = S_DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         S_DONE: begin
            if (res_valid_q && bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;

   assign datain     = bus.in_data;
   assign write_mat  = xfer;
   assign mat_mux    = (state_q == S_LOAD_B);
   assign rst_mul    = xfer && (state_q == S_IDLE);
   assign inc_pc     = (state_q == S_MAC);
   assign mac_ctrl   = (state_q == S_MAC);
   assign pc_counter = pc_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pe_sequencer.sv
// Randomized bench for pe_sequencer: a dot-product PE model feeds DATAOUT and
// a job-level scoreboard predicts every control output cycle by cycle.
module tb_pe_sequencer;
   localparam int N  = 16;
   localparam int D  = 2;
   localparam int N2 = 5;
   localparam int D2 = 1;

   typedef logic [N-1:0][31:0] vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance
   pe_seq_if #(.N(N)) bus ();
   vec_t         datain;
   logic         write_mat, mat_mux, inc_pc, mac_ctrl, rst_mul, busy;
   logic [3:0]   pc_counter;
   logic [31:0]  dataout;

   pe_sequencer #(.N(N), .DRAIN_CYC(D)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .datain     (datain),
      .write_mat  (write_mat),
      .mat_mux    (mat_mux),
      .inc_pc     (inc_pc),
      .mac_ctrl   (mac_ctrl),
      .rst_mul    (rst_mul),
      .pc_counter (pc_counter),
      .dataout    (dataout),
      .busy       (busy)
   );

   // Non-power-of-two instance
   pe_seq_if #(.N(N2)) bus2 ();
   logic [N2-1:0][31:0] datain2;
   logic         write_mat2, mat_mux2, inc_pc2, mac_ctrl2, rst_mul2, busy2;
   logic [2:0]   pc_counter2;
   logic [31:0]  dataout2;

   pe_sequencer #(.N(N2), .DRAIN_CYC(D2)) u_small (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus2),
      .datain     (datain2),
      .write_mat  (write_mat2),
      .mat_mux    (mat_mux2),
      .inc_pc     (inc_pc2),
      .mac_ctrl   (mac_ctrl2),
      .rst_mul    (rst_mul2),
      .pc_counter (pc_counter2),
      .dataout    (dataout2),
      .busy       (busy2)
   );

   // PE model: A/B register files plus a multiply-accumulate over lane pc
   logic [31:0] mat_a [N];
   logic [31:0] mat_b [N];
   logic [31:0] acc = '0;

   always @(posedge clk) begin
      if (write_mat && !mat_mux) for (int i = 0; i < N; i++) mat_a[i] <= datain[i];
      if (write_mat &&  mat_mux) for (int i = 0; i < N; i++) mat_b[i] <= datain[i];
      if (rst_mul)       acc <= '0;
      else if (mac_ctrl) acc <= acc + mat_a[pc_counter] * mat_b[pc_counter];
   end
   assign dataout = acc;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] dot(input vec_t a, input vec_t b);
      logic [31:0] s = '0;
      for (int i = 0; i < N; i++) s += a[i] * b[i];
      return s;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < N; i++) v[i] = (($urandom % 4) == 0) ? $urandom : $urandom_range(0, 2000);
      return v;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Full job starting from IDLE; returns one cycle after the result handshake
   task automatic run_job(input vec_t a, input vec_t b, input logic [31:0] exp,
                          input int gap, input bit noise, input int bp);
      bus.in_valid  = 1'b1;
      bus.in_data   = a;
      bus.res_ready = 1'($urandom);
      @(negedge clk);
      check("idle_in_ready", bus.in_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_res_valid", bus.res_valid, 0);
      check("a_write_mat", write_mat, 1);
      check("a_rst_mul", rst_mul, 1);
      check("a_mat_mux", mat_mux, 0);
      check("a_datain_last", datain[N-1], a[N-1]);
      next_cycle();

      for (int g = 0; g < gap; g++) begin
         bus.in_valid = 1'b0;
         bus.in_data  = rand_vec();
         @(negedge clk);
         check("gap_write_mat", write_mat, 0);
         check("gap_mat_mux", mat_mux, 1);
         check("gap_in_ready", bus.in_ready, 1);
         check("gap_busy", busy, 1);
         check("gap_inc_pc", inc_pc, 0);
         next_cycle();
      end

      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(negedge clk);
      check("b_write_mat", write_mat, 1);
      check("b_mat_mux", mat_mux, 1);
      check("b_rst_mul", rst_mul, 0);
      next_cycle();

      for (int k = 0; k < N; k++) begin
         bus.in_valid  = noise ? 1'b1 : 1'($urandom);
         bus.in_data   = rand_vec();
         bus.res_ready = 1'($urandom);
         @(negedge clk);
         check("mac_inc_pc", inc_pc, 1);
         check("mac_ctrl", mac_ctrl, 1);
         check("mac_pc", 32'(pc_counter), k);
         check("mac_write_mat", write_mat, 0);
         check("mac_in_ready", bus.in_ready, 0);
         next_cycle();
      end

      for (int d = 0; d < D; d++) begin
         bus.in_valid  = noise ? 1'b1 : 1'($urandom);
         bus.res_ready = 1'($urandom);
         @(negedge clk);
         check("drain_inc_pc", inc_pc, 0);
         check("drain_pc", 32'(pc_counter), 0);
         check("drain_res_valid", bus.res_valid, 0);
         check("drain_busy", busy, 1);
         check("drain_write_mat", write_mat, 0);
         next_cycle();
      end

      for (int w = 0; w < bp; w++) begin
         bus.in_valid  = noise ? 1'b1 : 1'($urandom);
         bus.res_ready = 1'b0;
         @(negedge clk);
         check("done_res_valid", bus.res_valid, 1);
         check("done_res_data", bus.res_data, exp);
         check("done_busy", busy, 1);
         check("done_in_ready", bus.in_ready, 0);
         check("done_write_mat", write_mat, 0);
         next_cycle();
      end

      bus.res_ready = 1'b1;
      @(negedge clk);
      check("hs_res_valid", bus.res_valid, 1);
      check("hs_res_data", bus.res_data, exp);
      next_cycle();
      bus.res_ready = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid  = 1'b0;
         bus.in_data   = rand_vec();
         bus.res_ready = 1'($urandom);
         @(negedge clk);
         check("idle_res_valid_hold", bus.res_valid, 0);
         check("idle_busy_hold", busy, 0);
         check("idle_write_mat", write_mat, 0);
         next_cycle();
      end
   endtask

   task automatic reset_mid_mac();
      bus.in_valid = 1'b1;
      bus.in_data  = rand_vec();
      next_cycle();
      bus.in_data  = rand_vec();
      next_cycle();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 7; k++) next_cycle();
      @(negedge clk);
      check("rst_pre_pc", 32'(pc_counter), 7);
      #2 rst_n = 1'b0;
      #1;
      check("rst_pc", 32'(pc_counter), 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_inc_pc", inc_pc, 0);
      check("rst_mac_ctrl", mac_ctrl, 0);
      check("rst_mat_mux", mat_mux, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data", bus.res_data, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      next_cycle();
      idle_cycles(N + D + 4);
   endtask

   task automatic small_job();
      logic [31:0] pe_val;
      pe_val   = $urandom;
      dataout2 = pe_val;
      bus2.in_valid = 1'b1;
      for (int i = 0; i < N2; i++) bus2.in_data[i] = $urandom;
      next_cycle();
      next_cycle();
      bus2.in_valid = 1'b0;
      for (int k = 0; k < N2; k++) begin
         @(negedge clk);
         check("n5_inc_pc", inc_pc2, 1);
         check("n5_pc", 32'(pc_counter2), k);
         next_cycle();
      end
      for (int d = 0; d < D2; d++) begin
         @(negedge clk);
         check("n5_drain_pc_wrap", 32'(pc_counter2), 0);
         check("n5_drain_res_valid", bus2.res_valid, 0);
         next_cycle();
      end
      bus2.res_ready = 1'b1;
      @(negedge clk);
      check("n5_res_valid", bus2.res_valid, 1);
      check("n5_res_data", bus2.res_data, pe_val);
      next_cycle();
      bus2.res_ready = 1'b0;
      @(negedge clk);
      check("n5_res_cleared", bus2.res_valid, 0);
      check("n5_idle", busy2, 0);
   endtask

   initial begin
      vec_t a, b;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.res_ready  = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.res_ready = 1'b0;
      dataout2       = '0;

      #3;
      check("por_pc", 32'(pc_counter), 0);
      check("por_busy", busy, 0);
      check("por_in_ready", bus.in_ready, 1);
      check("por_res_valid", bus.res_valid, 0);
      check("por_res_data", bus.res_data, 0);
      check("por_mat_mux", mat_mux, 0);
      #9 rst_n = 1'b1;
      next_cycle();

      for (int i = 0; i < N; i++) a[i] = 32'(i + 1);
      run_job(a, a, 32'd1496, 0, 1'b1, 5);

      a = rand_vec();
      b = rand_vec();
      run_job(a, b, dot(a, b), 3, 1'b0, $urandom_range(0, 3));

      for (int j = 0; j < 6; j++) begin
         a = rand_vec();
         b = rand_vec();
         run_job(a, b, dot(a, b), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 4));
         idle_cycles($urandom_range(0, 2));
      end

      reset_mid_mac();
      a = rand_vec();
      b = rand_vec();
      run_job(a, b, dot(a, b), 1, 1'b0, 1);

      small_job();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
